// File: rtl/bus_pkg.sv
// Shared definitions for the core-bus arbiter family: FSM encodings,
// master indices and the default access timeout.
package bus_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/busarb_rrpick.sv
// Two-way round-robin picker: on a tie the master not granted last wins.
module rrpick
    import bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);
    always_comb begin
        valid = |req;
        grant = M0;
        if (&req)
            grant = ~last;
        else if (req[1])
            grant = M1;
    end
endmodule

// File: rtl/busarb.sv
// Two-master core-bus arbiter: grants m0/m1 round-robin, runs one device
// access at a time and returns a single ack or err pulse to the owner.
module busarb
    import bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [31:0] m0_wdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] rdata,
    output logic        en,
    output logic [31:0] addr,
    output logic        we,
    output logic [31:0] wdata,
    input  logic [31:0] dev_rdata,
    input  logic        ready,
    input  logic        claimed
);
    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_t        state, state_nxt;
    logic          last, last_nxt;
    logic          owner, owner_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic          en_nxt, we_nxt;
    logic [31:0]   addr_nxt, wdata_nxt, rdata_nxt;
    logic [1:0]    ack_q, err_q, ack_nxt, err_nxt;
    logic          gnt, gvld;

    rrpick u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last),
        .grant (gnt),
        .valid (gvld)
    );

    // Saturating so a long stall can never wrap back under the limit.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        en_nxt    = en;
        we_nxt    = we;
        addr_nxt  = addr;
        wdata_nxt = wdata;
        rdata_nxt = rdata;
        ack_nxt   = '0;
        err_nxt   = '0;
        case (state)
            IDLE: begin
                if (gvld) begin
                    owner_nxt = gnt;
                    addr_nxt  = gnt ? m1_addr  : m0_addr;
                    we_nxt    = gnt ? m1_we    : m0_we;
                    wdata_nxt = gnt ? m1_wdata : m0_wdata;
                    cnt_nxt   = '0;
                    en_nxt    = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                cnt_nxt = cnt_inc;
                // A missing claim outranks ready: nobody decoded the address.
                if (!claimed) begin
                    err_nxt[owner] = 1'b1;
                end else if (ready) begin
                    ack_nxt[owner] = 1'b1;
                    if (!we)
                        rdata_nxt = dev_rdata;
                end else if (cnt_inc == CNT_MAX) begin
                    err_nxt[owner] = 1'b1;
                end
                if (|(ack_nxt | err_nxt)) begin
                    en_nxt    = 1'b0;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                last_nxt  = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            last  <= M1;
            owner <= M0;
            cnt   <= '0;
            en    <= 1'b0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            rdata <= '0;
            ack_q <= '0;
            err_q <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
            en    <= en_nxt;
            we    <= we_nxt;
            addr  <= addr_nxt;
            wdata <= wdata_nxt;
            rdata <= rdata_nxt;
            ack_q <= ack_nxt;
            err_q <= err_nxt;
        end
    end

    assign m0_ack = ack_q[0];
    assign m1_ack = ack_q[1];
    assign m0_err = err_q[0];
    assign m1_err = err_q[1];
endmodule

// File: tb/tb_busarb.sv
// Bench for busarb: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_busarb;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [1:0]  mreq = '0;
    logic [1:0]  mwe = '0;
    logic [31:0] maddr [2];
    logic [31:0] mwdata [2];
    logic [31:0] dev_rdata = '0;
    logic        ready = 1'b0;
    logic        claimed = 1'b0;
    logic        m0_ack, m0_err, m1_ack, m1_err, en, we;
    logic [31:0] rdata, addr, wdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    busarb #(.TIMEOUT(TO)) dut (
        .clk(clk), .n_rst(n_rst),
        .m0_req(mreq[0]), .m0_addr(maddr[0]), .m0_we(mwe[0]), .m0_wdata(mwdata[0]),
        .m1_req(mreq[1]), .m1_addr(maddr[1]), .m1_we(mwe[1]), .m1_wdata(mwdata[1]),
        .m0_ack(m0_ack), .m0_err(m0_err), .m1_ack(m1_ack), .m1_err(m1_err),
        .rdata(rdata), .en(en), .addr(addr), .we(we), .wdata(wdata),
        .dev_rdata(dev_rdata), .ready(ready), .claimed(claimed)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction record; outcome decided
    // from the device signals seen in each of its bus cycles.
    logic        x_busy, x_en, x_we, x_last, x_owner, x_was_pulse;
    logic [31:0] x_addr, x_wdata, x_rdata;
    logic [1:0]  x_ack, x_err;
    int          x_age;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_busy = 0; x_en = 0; x_we = 0; x_last = 1; x_owner = 0;
            x_addr = 0; x_wdata = 0; x_rdata = 0; x_ack = 0; x_err = 0; x_age = 0;
        end else begin
            x_was_pulse = |(x_ack | x_err);
            x_ack = 0;
            x_err = 0;
            if (x_busy) begin
                x_age++;
                if (!claimed) begin
                    x_err[x_owner] = 1; x_busy = 0;
                end else if (ready) begin
                    x_ack[x_owner] = 1; x_busy = 0;
                    if (!x_we) x_rdata = dev_rdata;
                end else if (x_age == TO) begin
                    x_err[x_owner] = 1; x_busy = 0;
                end
                x_en = x_busy;
            end else if (x_was_pulse) begin
                x_last = x_owner;
            end else if (mreq != 2'b00) begin
                x_owner = (mreq == 2'b11) ? !x_last : mreq[1];
                x_addr  = maddr[x_owner];
                x_we    = mwe[x_owner];
                x_wdata = mwdata[x_owner];
                x_busy  = 1; x_en = 1; x_age = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("pulses", 32'({m0_ack, m0_err, m1_ack, m1_err}),
            32'({x_ack[0], x_err[0], x_ack[1], x_err[1]}));
        chk("en", 32'(en), 32'(x_en));
        chk("rdata", rdata, x_rdata);
        if (x_en) begin
            chk("addr", addr, x_addr);
            chk("we", 32'(we), 32'(x_we));
            chk("wdata", wdata, x_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    logic [1:0] done;

    initial begin
        maddr[0] = 0; maddr[1] = 0; mwdata[0] = 0; mwdata[1] = 0;
        repeat (3) tick();
        chk("rst_en", 32'(en), 0);
        chk("rst_addr", addr, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_pulses", 32'({m0_ack, m0_err, m1_ack, m1_err}), 0);
        n_rst = 1;
        tick();

        // m0 read, claimed and ready in first access cycle
        mreq[0] = 1; maddr[0] = 32'h0000_1004; mwe[0] = 0;
        claimed = 1; ready = 1; dev_rdata = 32'hDEAD_BEEF;
        tick();
        chk("d1_en_c1", 32'(en), 1);
        chk("d1_addr", addr, 32'h0000_1004);
        chk("d1_ack_c1", 32'(m0_ack), 0);
        tick();
        chk("d1_ack_c2", 32'(m0_ack), 1);
        chk("d1_rdata", rdata, 32'hDEAD_BEEF);
        chk("d1_model_rdata", x_rdata, 32'hDEAD_BEEF);
        chk("d1_en_c2", 32'(en), 0);
        mreq[0] = 0;
        tick();
        chk("d1_ack_c3", 32'(m0_ack), 0);

        // m1 write to an unclaimed address
        mreq[1] = 1; maddr[1] = 32'h4000_0000; mwe[1] = 1; mwdata[1] = 32'h1234_5678;
        claimed = 0; ready = 0;
        tick();
        chk("d2_en", 32'(en), 1);
        chk("d2_we", 32'(we), 1);
        tick();
        chk("d2_err", 32'(m1_err), 1);
        chk("d2_ack", 32'(m1_ack), 0);
        chk("d2_rdata", rdata, 32'hDEAD_BEEF);
        mreq[1] = 0;
        tick();

        // timeout: claimed but never ready
        mreq[0] = 1; maddr[0] = 32'h0000_2000; mwe[0] = 0; claimed = 1; ready = 0;
        for (int k = 1; k <= TO; k++) begin
            tick();
            chk("d3_en", 32'(en), 1);
            chk("d3_noerr", 32'(m0_err), 0);
        end
        tick();
        chk("d3_err", 32'(m0_err), 1);
        chk("d3_model_err", 32'(x_err[0]), 1);
        chk("d3_en_off", 32'(en), 0);
        mreq[0] = 0;
        tick();

        // both masters continuously requesting from reset
        n_rst = 0; tick(); n_rst = 1; tick();
        mreq = 2'b11; maddr[0] = 32'h10; maddr[1] = 32'h20; mwe = 2'b00;
        claimed = 1; ready = 1; dev_rdata = 32'h0000_0077;
        for (int j = 1; j <= 12; j++) begin
            tick();
            chk("d4_m0_ack", 32'(m0_ack), 32'(j == 2 || j == 8));
            chk("d4_m1_ack", 32'(m1_ack), 32'(j == 5 || j == 11));
        end
        mreq = 2'b00;
        repeat (3) tick();

        // reset in the middle of an access, then the held request reruns
        mreq[0] = 1; maddr[0] = 32'h0000_3000; mwe[0] = 0; claimed = 1; ready = 0;
        tick();
        chk("d5_en", 32'(en), 1);
        n_rst = 0;
        #1;
        chk("d5_en_rst", 32'(en), 0);
        chk("d5_pulses_rst", 32'({m0_ack, m0_err, m1_ack, m1_err}), 0);
        tick();
        n_rst = 1; ready = 1; dev_rdata = 32'h0BAD_F00D;
        tick();
        chk("d5_en_again", 32'(en), 1);
        tick();
        chk("d5_ack", 32'(m0_ack), 1);
        chk("d5_rdata", rdata, 32'h0BAD_F00D);
        mreq[0] = 0; ready = 0;
        tick();

        // m1 abandons its request mid-access; the pulse still arrives
        mreq[1] = 1; maddr[1] = 32'h0000_4000; mwe[1] = 0; claimed = 1; ready = 0;
        tick();
        chk("d6_en", 32'(en), 1);
        mreq[1] = 0;
        tick();
        chk("d6_en2", 32'(en), 1);
        ready = 1; dev_rdata = 32'hA5A5_0001;
        tick();
        chk("d6_ack", 32'(m1_ack), 1);
        chk("d6_rdata", rdata, 32'hA5A5_0001);
        ready = 0;
        tick();
        chk("d6_ack_once", 32'(m1_ack), 0);
        chk("d6_idle_en", 32'(en), 0);

        // randomized traffic
        done = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                logic pulse;
                pulse = (i == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err);
                if (done[i]) begin
                    done[i] = 0;
                    mreq[i] = $urandom_range(1);
                    maddr[i] = $urandom; mwe[i] = $urandom_range(1); mwdata[i] = $urandom;
                end else if (pulse) begin
                    done[i] = 1;
                end else if (!mreq[i] && $urandom_range(2) == 0) begin
                    mreq[i] = 1;
                    maddr[i] = $urandom; mwe[i] = $urandom_range(1); mwdata[i] = $urandom;
                end else if (mreq[i] && $urandom_range(24) == 0) begin
                    mreq[i] = 0;
                end
            end
            claimed = ($urandom_range(9) != 0);
            ready = ($urandom_range(2) == 0);
            dev_rdata = $urandom;
        end
        mreq = 2'b00;
        repeat (TO + 4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/busarb.md
# busarb

Two-master bus arbiter and transaction sequencer for the 32-bit core bus. Shares the single device bus between the instruction-fetch master (m0) and the load/store master (m1) with round-robin priority. Drives the device-side enable/address that the per-device decoders consume. Converts each device's ready/claim signals into a one-cycle ack or error pulse back to the requesting master, including unclaimed-address and timeout errors.

## Interface
- TIMEOUT, 16: max ACCESS cycles without `ready` before error; legal range 1..255
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- m0_req / m1_req  in  1  transaction request, held until own ack/err
- m0_addr / m1_addr  in  32  byte address
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_wdata / m1_wdata  in  32  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  one-cycle error pulse (unclaimed or timeout)
- rdata  out  32  read data, valid with the ack of a read, held until next read ack
- en  out  1  device-bus enable (to all decoders)
- addr  out  32  device-bus address
- we  out  1  device-bus write strobe qualifier
- wdata  out  32  device-bus write data
- dev_rdata  in  32  read data from selected device
- ready  in  1  selected device completes this cycle
- claimed  in  1  OR of all decoder `busy` outputs

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req, pick master, latch its addr/we/wdata into bus registers, clear timeout counter, -> ACCESS. Otherwise stay.
- Pick rule: only one requesting -> that one. Both requesting -> the master not granted last. Pointer `last` resets to m1, so m0 wins the first tie.
- ACCESS: en=1, addr/we/wdata driven from latched registers; counter increments each cycle.
  - claimed=0 -> RESP with error.
  - Else ready=1 -> RESP with ack; latch dev_rdata into rdata if read.
  - Else counter reaches TIMEOUT -> RESP with error.
  - claimed=0 and ready=1 in the same cycle -> error (claim wins).
- RESP: exactly one of granted m*_ack / m*_err high for one cycle; en=0; update `last`; -> IDLE.
- Master dropping req during ACCESS does not abort: transaction completes, pulse still issued.
- Write ack leaves rdata unchanged.
- Non-granted master sees no ack/err; its req stays pending.

## Timing
- Reset (async assert): state=IDLE, en=0, addr=0, we=0, wdata=0, rdata=0, all ack/err=0, counter=0, last=m1. In-flight transaction discarded, no pulse issued.
- Release is sampled on the next rising edge; first arbitration occurs on the edge after release.
- Latency: req seen in IDLE at cycle 0 -> en high in cycle 1 -> ready in cycle 1 -> ack in cycle 2 -> IDLE in cycle 3. Minimum 3 cycles per transaction.
- Back-to-back: a master may re-request in the cycle after its ack. Both masters continuously requesting alternate m0, m1, m0, ...
- Timeout: ready never high -> err in cycle TIMEOUT+1 after entering ACCESS (TIMEOUT ACCESS cycles).
- Counter width $clog2(TIMEOUT+1) and saturating, so it never wraps.
- All outputs registered; no combinational path from master inputs to device bus.

## Structure
- Shared package `bus_pkg`:
  - state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - master index constants M0=1'b0, M1=1'b1;
  - default TIMEOUT.
- One sub-module, `rrpick`: two-way round-robin picker. Inputs req[1:0] and last; outputs grant index and valid. Purely combinational, reused by future N-master variants.

## Test plan
- m0 reads 0x00001004, device claims, ready in first ACCESS cycle with dev_rdata=0xDEADBEEF -> m0_ack at cycle 2, rdata=0xDEADBEEF, en high exactly cycle 1.
- m0 and m1 both request continuously from reset -> grants order m0, m1, m0, m1; each ack 3 cycles apart.
- m1 writes 0x40000000 with claimed=0 -> m1_err pulse at cycle 2, no ack, rdata unchanged.
- TIMEOUT=4, claimed=1, ready held 0 -> m0_err exactly 5 cycles after req seen, en high 4 cycles.
- n_rst asserted mid-ACCESS (cycle 1) -> en, ack, err immediately 0. After release, the held m0 req is re-arbitrated and completes normally.
- m1 drops req during ACCESS, ready arrives 2 cycles later -> m1_ack still pulses once, FSM returns to IDLE.
